// File: rtl/mist_sector_client.sv
// Sector bridge between the PC-88 FDC emulation and the hps_io virtual-disk channel.
// One read/write request at a time; the 512-byte sector lives in a local dual-port RAM.
module mist_sector_client #(
   parameter int TIMEOUT_W = 24
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [1:0]  req_drive,
   input  logic [31:0] req_lba,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic [8:0]  buf_addr,
   input  logic [7:0]  buf_wdat,
   input  logic        buf_we,
   output logic [7:0]  buf_rdat,
   input  logic [3:0]  img_mounted,
   output logic [31:0] sd_lba,
   output logic [3:0]  sd_rd,
   output logic [3:0]  sd_wr,
   input  logic [3:0]  sd_ack,
   input  logic [8:0]  sd_buff_addr,
   input  logic [7:0]  sd_buff_dout,
   input  logic        sd_buff_wr,
   output logic [7:0]  sd_buff_din
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;

   localparam logic [TIMEOUT_W-1:0] TMO_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_W-1:0] TMO_MAX = {TIMEOUT_W{1'b1}};

   logic [1:0]           state;
   logic [1:0]           drv;
   logic                 dir;       // 1: buffer -> image (write), 0: image -> buffer (read)
   logic [TIMEOUT_W-1:0] tmo_cnt;
   logic [TIMEOUT_W-1:0] tmo_next;
   logic                 ack_sel;
   logic                 abort_sel;
   logic [7:0]           ram [0:511];

   assign ack_sel   = sd_ack[drv];
   assign abort_sel = img_mounted[drv];
   assign tmo_next  = tmo_cnt + TMO_ONE;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= ST_IDLE;
         drv     <= 2'd0;
         dir     <= 1'b0;
         tmo_cnt <= '0;
         sd_lba  <= 32'd0;
         sd_rd   <= 4'd0;
         sd_wr   <= 4'd0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_rd || req_wr) begin
                  drv     <= req_drive;
                  sd_lba  <= req_lba;
                  dir     <= !req_rd;
                  tmo_cnt <= '0;
                  if (req_rd) sd_rd <= 4'b0001 << req_drive;
                  else        sd_wr <= 4'b0001 << req_drive;
                  state   <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (abort_sel) begin
                  sd_rd <= 4'd0;
                  sd_wr <= 4'd0;
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else if (ack_sel) begin
                  sd_rd <= 4'd0;
                  sd_wr <= 4'd0;
                  state <= ST_XFER;
               end else begin
                  // Error is flagged on the edge where the counter becomes all-ones.
                  tmo_cnt <= tmo_next;
                  if (tmo_next == TMO_MAX) begin
                     sd_rd <= 4'd0;
                     sd_wr <= 4'd0;
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_XFER: begin
               // XFER is only entered with ack high, so the first low sample is the falling edge.
               if (abort_sel) begin
                  err   <= 1'b1;
                  state <= ST_IDLE;
               end else if (!ack_sel) begin
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Port A writes only while idle and port B only in XFER, so the two never collide.
   always_ff @(posedge clk_sys) begin
      if (buf_we && !busy)
         ram[buf_addr] <= buf_wdat;
      else if (state == ST_XFER && !dir && sd_buff_wr)
         ram[sd_buff_addr] <= sd_buff_dout;
      buf_rdat    <= ram[buf_addr];
      sd_buff_din <= ram[sd_buff_addr];
   end

endmodule

// File: tb/tb_mist_sector_client.sv
// Bench for mist_sector_client: request table, directed transfer/abort sequences,
// and randomized buffer traffic checked against a byte-array model of the sector.
module tb_mist_sector_client;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        req_rd, req_wr;
   logic [1:0]  req_drive;
   logic [31:0] req_lba;
   logic        busy, done, err;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_wdat;
   logic        buf_we;
   logic [7:0]  buf_rdat;
   logic [3:0]  img_mounted;
   logic [31:0] sd_lba;
   logic [3:0]  sd_rd, sd_wr, sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic        sd_buff_wr;
   logic [7:0]  sd_buff_din;

   mist_sector_client #(.TIMEOUT_W(4)) dut (
      .clk_sys(clk_sys), .reset(reset),
      .req_rd(req_rd), .req_wr(req_wr), .req_drive(req_drive), .req_lba(req_lba),
      .busy(busy), .done(done), .err(err),
      .buf_addr(buf_addr), .buf_wdat(buf_wdat), .buf_we(buf_we), .buf_rdat(buf_rdat),
      .img_mounted(img_mounted), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  drv;
      logic [31:0] lba;
      logic [3:0]  exp_rd;
      logic [3:0]  exp_wr;
   } req_vec_t;

   logic [7:0] model [0:511];
   int check_cnt = 0;
   int pass_cnt  = 0;
   int done_cnt  = 0;
   int err_cnt   = 0;

   always @(negedge clk_sys) begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [1:0] d, input logic [31:0] lba);
      req_rd = rd; req_wr = wr; req_drive = d; req_lba = lba;
      tick();
      req_rd = 1'b0; req_wr = 1'b0;
   endtask

   task automatic fdc_write(input logic [8:0] a, input logic [7:0] d);
      buf_addr = a; buf_wdat = d; buf_we = 1'b1;
      tick();
      buf_we = 1'b0;
   endtask

   task automatic fdc_read_check(input string name, input logic [8:0] a);
      buf_addr = a;
      tick();
      check(name, {24'd0, buf_rdat}, {24'd0, model[a]});
   endtask

   // mode 0: every byte strobed with i^0x5A; mode 1: random data, random subset strobed
   task automatic read_xfer(input logic [1:0] d, input logic [31:0] lba, input int mode);
      int dc0;
      logic [3:0] exp_bit;
      logic [7:0] b;
      logic strobe;
      dc0 = done_cnt;
      exp_bit = 4'b0001 << d;
      issue(1'b1, 1'b0, d, lba);
      check("rd_req_bit", {28'd0, sd_rd}, {28'd0, exp_bit});
      check("rd_lba", sd_lba, lba);
      check("rd_busy", {31'd0, busy}, 32'd1);
      sd_ack[d] = 1'b1;
      tick();
      check("rd_req_clear", {28'd0, sd_rd}, 32'd0);
      for (int i = 0; i < 512; i++) begin
         b = (mode == 0) ? (i[7:0] ^ 8'h5A) : 8'($urandom);
         strobe = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
         sd_buff_addr = i[8:0]; sd_buff_dout = b; sd_buff_wr = strobe;
         tick();
         if (strobe) model[i] = b;
      end
      sd_buff_wr = 1'b0;
      sd_ack[d] = 1'b0;
      tick();
      check("rd_done", {31'd0, done}, 32'd1);
      check("rd_busy_end", {31'd0, busy}, 32'd0);
      tick();
      check("rd_done_once", done_cnt, dc0 + 1);
   endtask

   initial begin
      req_vec_t vecs [4];
      int dc0, ec0, seen;

      vecs[0] = '{rd: 1'b1, wr: 1'b0, drv: 2'd1, lba: 32'h12,       exp_rd: 4'b0010, exp_wr: 4'b0000};
      vecs[1] = '{rd: 1'b0, wr: 1'b1, drv: 2'd0, lba: 32'hDEADBEEF, exp_rd: 4'b0000, exp_wr: 4'b0001};
      vecs[2] = '{rd: 1'b1, wr: 1'b1, drv: 2'd2, lba: 32'h0000_0300, exp_rd: 4'b0100, exp_wr: 4'b0000};
      vecs[3] = '{rd: 1'b0, wr: 1'b1, drv: 2'd3, lba: 32'hFFFF_FFFF, exp_rd: 4'b0000, exp_wr: 4'b1000};

      reset = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_drive = 2'd0; req_lba = 32'd0;
      buf_addr = 9'd0; buf_wdat = 8'd0; buf_we = 1'b0; img_mounted = 4'd0;
      sd_ack = 4'd0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0; sd_buff_wr = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err",  {31'd0, err},  32'd0);
      check("rst_sd_rd", {28'd0, sd_rd}, 32'd0);
      check("rst_sd_wr", {28'd0, sd_wr}, 32'd0);
      check("rst_sd_lba", sd_lba, 32'd0);

      // Request launch table; each request is left unacknowledged to time out.
      for (int v = 0; v < 4; v++) begin
         dc0 = done_cnt; ec0 = err_cnt; seen = 0;
         issue(vecs[v].rd, vecs[v].wr, vecs[v].drv, vecs[v].lba);
         check("tbl_busy", {31'd0, busy}, 32'd1);
         check("tbl_sd_rd", {28'd0, sd_rd}, {28'd0, vecs[v].exp_rd});
         check("tbl_sd_wr", {28'd0, sd_wr}, {28'd0, vecs[v].exp_wr});
         check("tbl_sd_lba", sd_lba, vecs[v].lba);
         for (int k = 1; k <= 20; k++) begin
            tick();
            if (err) begin
               seen = k;
               break;
            end
         end
         check("tmo_cycles", seen, 15);
         check("tmo_sd_rd", {28'd0, sd_rd}, 32'd0);
         check("tmo_sd_wr", {28'd0, sd_wr}, 32'd0);
         check("tmo_busy", {31'd0, busy}, 32'd0);
         tick();
         check("tmo_err_once", err_cnt, ec0 + 1);
         check("tmo_no_done", done_cnt, dc0);
      end

      // Read slot 1, LBA 0x12, full sector of i^0x5A.
      read_xfer(2'd1, 32'h12, 0);
      buf_addr = 9'h000; tick();
      check("rd_byte_000", {24'd0, buf_rdat}, 32'h5A);
      buf_addr = 9'h0FF; tick();
      check("rd_byte_0ff", {24'd0, buf_rdat}, 32'hA5);
      for (int i = 0; i < 512; i++) fdc_read_check("rd_readback", i[8:0]);

      // Write slot 0 from a buffer preloaded with i&0xFF.
      for (int i = 0; i < 512; i++) begin
         fdc_write(i[8:0], i[7:0]);
         model[i] = i[7:0];
      end
      dc0 = done_cnt;
      issue(1'b0, 1'b1, 2'd0, 32'h40);
      check("wr_sd_wr", {28'd0, sd_wr}, 32'h1);
      check("wr_sd_rd", {28'd0, sd_rd}, 32'h0);
      sd_ack[0] = 1'b1;
      tick();
      check("wr_req_clear", {28'd0, sd_wr}, 32'h0);
      for (int i = 0; i < 512; i++) begin
         sd_buff_addr = i[8:0];
         sd_buff_wr = (i == 7);
         sd_buff_dout = 8'hEE;
         tick();
         check("wr_sd_buff_din", {24'd0, sd_buff_din}, {24'd0, model[i]});
      end
      sd_buff_wr = 1'b0;
      sd_ack[0] = 1'b0;
      tick();
      check("wr_done", {31'd0, done}, 32'd1);
      tick();
      check("wr_done_once", done_cnt, dc0 + 1);
      fdc_read_check("wr_strobe_ignored", 9'd7);

      // Collisions during a read on slot 1, then abort by remount.
      dc0 = done_cnt; ec0 = err_cnt;
      issue(1'b1, 1'b0, 2'd1, 32'h77);
      issue(1'b1, 1'b0, 2'd3, 32'h99);
      check("drop_lba", sd_lba, 32'h77);
      check("drop_sd_rd", {28'd0, sd_rd}, 32'h2);
      fdc_write(9'd5, 8'hC3);
      sd_ack[2] = 1'b1;
      tick();
      check("foreign_ack_rd", {28'd0, sd_rd}, 32'h2);
      check("foreign_ack_busy", {31'd0, busy}, 32'd1);
      sd_ack[2] = 1'b0;
      sd_ack[1] = 1'b1;
      tick();
      check("abort_req_clear", {28'd0, sd_rd}, 32'h0);
      img_mounted[1] = 1'b1;
      tick();
      img_mounted[1] = 1'b0;
      check("abort_err", {31'd0, err}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      sd_ack[1] = 1'b0;
      tick();
      check("abort_err_once", err_cnt, ec0 + 1);
      check("abort_no_done", done_cnt, dc0);
      fdc_read_check("we_while_busy", 9'd5);

      // Reset in the middle of a read transfer.
      dc0 = done_cnt; ec0 = err_cnt;
      issue(1'b1, 1'b0, 2'd2, 32'h1234);
      sd_ack[2] = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         sd_buff_addr = i[8:0]; sd_buff_dout = 8'h30 + i[7:0]; sd_buff_wr = 1'b1;
         tick();
         model[i] = 8'h30 + i[7:0];
      end
      sd_buff_wr = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sd_ack[2] = 1'b0;
      check("rstx_busy", {31'd0, busy}, 32'd0);
      check("rstx_sd_rd", {28'd0, sd_rd}, 32'd0);
      check("rstx_lba", sd_lba, 32'd0);
      tick(); tick();
      check("rstx_no_done", done_cnt, dc0);
      check("rstx_no_err", err_cnt, ec0);
      read_xfer(2'd2, 32'h5678, 1);
      for (int i = 0; i < 16; i++) fdc_read_check("rstx_readback", 9'($urandom_range(0, 511)));

      // Randomized FDC traffic and sd transfers against the byte model.
      for (int n = 0; n < 3; n++) begin
         for (int j = 0; j < 100; j++) begin
            logic [8:0] a;
            logic [7:0] d;
            a = 9'($urandom_range(0, 511));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               fdc_write(a, d);
               model[a] = d;
            end else begin
               fdc_read_check("rand_fdc_read", a);
            end
         end
         read_xfer(2'($urandom_range(0, 3)), $urandom, 1);
         for (int j = 0; j < 32; j++) fdc_read_check("rand_xfer_read", 9'($urandom_range(0, 511)));
      end

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
